// File: rtl/adc_link_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_link_pkg : shared constants, FSM encoding and channel-tag helper
// Rev 1.0
// ---------------------------------------------------------------------------
package adc_link_pkg;

  localparam int   DEF_DATA_W   = 16;
  localparam int   DEF_CH_W     = 8;
  localparam logic DEF_IDLE_LVL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Channel tag layout seen by the scan controller: {F2_4ADD, F2_8ADD, F1_8ADD}
  function automatic logic [7:0] pack_ch(input logic [1:0] f2_4add,
                                         input logic [2:0] f2_8add,
                                         input logic [2:0] f1_8add);
    return {f2_4add, f2_8add, f1_8add};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge_det : 2-FF synchronizer with registered rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_edge_det
  import adc_link_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  // Reset to the pin's idle level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/adc_sdo_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_sdo_responder : ADC-style SDO responder, one held sample per cs_n frame
// Rev 1.0
// ---------------------------------------------------------------------------
module adc_sdo_responder
  import adc_link_pkg::*;
#(
  parameter int   DATA_W   = DEF_DATA_W,
  parameter int   CH_W     = DEF_CH_W,
  parameter logic IDLE_LVL = DEF_IDLE_LVL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic [CH_W-1:0]   mux_sel,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              sdo,
  output logic              frame_done,
  output logic [CH_W-1:0]   frame_ch,
  output logic              overrun,
  output logic [7:0]        abort_cnt
);

  localparam int CNT_W = $clog2(DATA_W);

  logic w_cs_rise, w_cs_fall, w_sclk_fall, w_sclk_rise_unused;

  sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (cs_n),
    .rise  (w_cs_rise),
    .fall  (w_cs_fall)
  );

  // SDO only changes on falling edges; the rising edges belong to the master
  sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (sclk),
    .rise  (w_sclk_rise_unused),
    .fall  (w_sclk_fall)
  );

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              sdo_q, sdo_d;
  logic              frame_done_q, frame_done_d;
  logic [CH_W-1:0]   frame_ch_q, frame_ch_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        abort_cnt_q, abort_cnt_d;

  logic              w_load_fire;
  logic              w_accept;
  logic [DATA_W-1:0] w_load_src;

  // A LOAD cut short by cs_n leaves the held sample for the next frame
  assign w_load_fire  = (state_q == ST_LOAD) && !w_cs_rise;
  assign sample_ready = !hold_full_q || w_load_fire;
  assign w_accept     = sample_valid && sample_ready;
  assign w_load_src   = hold_full_q ? hold_q : last_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_d       = last_q;
    sdo_d        = sdo_q;
    frame_done_d = 1'b0;
    frame_ch_d   = frame_ch_q;
    overrun_d    = overrun_q;
    abort_cnt_d  = abort_cnt_q;

    if (w_load_fire) begin
      hold_full_d = 1'b0;
    end
    if (w_accept) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        sdo_d = IDLE_LVL;
        if (w_cs_fall) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_cs_rise) begin
          state_d = ST_IDLE;
          sdo_d   = IDLE_LVL;
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
        end else begin
          shift_d    = w_load_src;
          last_d     = w_load_src;
          frame_ch_d = mux_sel;
          bit_cnt_d  = CNT_W'(DATA_W - 1);
          sdo_d      = w_load_src[DATA_W-1];
          if (!hold_full_q) overrun_d = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          state_d = ST_IDLE;
          sdo_d   = IDLE_LVL;
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
        end else if (w_sclk_fall) begin
          if (bit_cnt_q == '0) begin
            state_d      = ST_DONE;
            sdo_d        = IDLE_LVL;
            frame_done_d = 1'b1;
          end else begin
            shift_d   = shift_q << 1;
            sdo_d     = shift_q[DATA_W-2];
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        sdo_d = IDLE_LVL;
        if (w_cs_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sdo_d   = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      sdo_q        <= IDLE_LVL;
      frame_done_q <= 1'b0;
      frame_ch_q   <= '0;
      overrun_q    <= 1'b0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_q       <= last_d;
      sdo_q        <= sdo_d;
      frame_done_q <= frame_done_d;
      frame_ch_q   <= frame_ch_d;
      overrun_q    <= overrun_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign sdo        = sdo_q;
  assign frame_done = frame_done_q;
  assign frame_ch   = frame_ch_q;
  assign overrun    = overrun_q;
  assign abort_cnt  = abort_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sdo_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adc_sdo_responder : directed self-checking bench for adc_sdo_responder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_adc_sdo_responder;
  import adc_link_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic [7:0]  mux_sel = 8'h00;
  logic [15:0] sample_data = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        sdo;
  logic        frame_done;
  logic [7:0]  frame_ch;
  logic        overrun;
  logic [7:0]  abort_cnt;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  adc_sdo_responder dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .mux_sel      (mux_sel),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sdo          (sdo),
    .frame_done   (frame_done),
    .frame_ch     (frame_ch),
    .overrun      (overrun),
    .abort_cnt    (abort_cnt)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_sample(input logic [15:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic frame_start(input logic [7:0] m);
    mux_sel = m;
    cs_n    = 1'b0;
    tick(6);
  endtask

  // sclk at clk/10: sdo is sampled just before each rising edge
  task automatic frame_bits(input int n, output logic [15:0] bits);
    bits = 16'h0000;
    for (int i = 0; i < n; i++) begin
      bits = {bits[14:0], sdo};
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL reset_sdo: got %b expected 1", sdo); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", sample_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (frame_ch !== 8'h00) begin errors++; $display("FAIL reset_ch: got %h expected 00", frame_ch); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (abort_cnt !== 8'h00) begin errors++; $display("FAIL reset_abort: got %h expected 00", abort_cnt); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_basic_frame();
    logic [15:0] b;
    int d0;
    load_sample(16'hA5C3);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_full: got %b expected 0", sample_ready); end
    d0 = done_seen;
    frame_start(pack_ch(2'b00, 3'b101, 3'b101));
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'hA5C3) begin errors++; $display("FAIL basic_bits: got %h expected a5c3", b); end
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_seen - d0); end
    checks++; if (frame_ch !== 8'h2D) begin errors++; $display("FAIL basic_ch: got %h expected 2d", frame_ch); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
    checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL basic_sdo_idle: got %b expected 1", sdo); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b;
    int d0;
    load_sample(16'h1234);
    d0 = done_seen;
    frame_start(8'h11);
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'h1234) begin errors++; $display("FAIL b2b_first_bits: got %h expected 1234", b); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_overrun: got %b expected 0", overrun); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_between: got %b expected 1", sample_ready); end
    frame_start(8'h22);
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'h1234) begin errors++; $display("FAIL b2b_repeat_bits: got %h expected 1234", b); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
    checks++; if (frame_ch !== 8'h22) begin errors++; $display("FAIL b2b_ch: got %h expected 22", frame_ch); end
    checks++; if (done_seen - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_seen - d0); end
  endtask

  task automatic test_abort();
    logic [15:0] b;
    int d0;
    load_sample(16'h00FF);
    d0 = done_seen;
    frame_start(8'h33);
    frame_bits(7, b);
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL abort_sdo_before: got %b expected 0", sdo); end
    cs_n = 1'b1;
    tick(4);
    checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL abort_sdo_idle: got %b expected 1", sdo); end
    tick(4);
    checks++; if (abort_cnt !== 8'h01) begin errors++; $display("FAIL abort_count: got %h expected 01", abort_cnt); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_seen - d0); end
    load_sample(16'h3C5A);
    frame_start(8'h44);
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'h3C5A) begin errors++; $display("FAIL abort_next_bits: got %h expected 3c5a", b); end
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL abort_next_done: got %0d expected 1", done_seen - d0); end
  endtask

  task automatic test_load_collision();
    logic [15:0] b;
    bit found;
    load_sample(16'h1111);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL coll_ready_full: got %b expected 0", sample_ready); end
    mux_sel      = 8'h96;
    sample_data  = 16'h2222;
    sample_valid = 1'b1;
    cs_n         = 1'b0;
    found        = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1);
      if (sample_ready === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL coll_load_window: got ready=0 expected ready=1 within 12 clk"); end
    tick(1);
    sample_valid = 1'b0;
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL coll_ready_after: got %b expected 0", sample_ready); end
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'h1111) begin errors++; $display("FAIL coll_old_bits: got %h expected 1111", b); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL coll_ready_hold: got %b expected 0", sample_ready); end
    frame_start(8'h5A);
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'h2222) begin errors++; $display("FAIL coll_new_bits: got %h expected 2222", b); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_free: got %b expected 1", sample_ready); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL coll_overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_idle_sclk();
    int d0;
    int bad;
    d0  = done_seen;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      for (int k = 0; k < 4; k++) begin
        tick(1);
        if (sdo !== 1'b1) bad++;
      end
    end
    tick(4);
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_sdo: got %0d low samples expected 0", bad); end
    checks++; if (abort_cnt !== 8'h01) begin errors++; $display("FAIL idle_abort: got %h expected 01", abort_cnt); end
    checks++; if (frame_ch !== 8'h5A) begin errors++; $display("FAIL idle_ch: got %h expected 5a", frame_ch); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL idle_done: got %0d expected 0", done_seen - d0); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", sample_ready); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] b;
    int d0;
    load_sample(16'hBEEF);
    frame_start(8'h3C);
    frame_bits(7, b);
    checks++; if (b[6:0] !== 7'h5F || sdo !== 1'b0) begin errors++; $display("FAIL rst_mid_prefix: got %h/%b expected 5f/0", b[6:0], sdo); end
    reset = 1'b1;
    cs_n  = 1'b1;
    tick(1);
    checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL rst_mid_sdo: got %b expected 1", sdo); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", sample_ready); end
    checks++; if (abort_cnt !== 8'h00) begin errors++; $display("FAIL rst_mid_abort: got %h expected 00", abort_cnt); end
    checks++; if (overrun !== 1'b0 || frame_ch !== 8'h00) begin errors++; $display("FAIL rst_mid_flags: got %b/%h expected 0/00", overrun, frame_ch); end
    reset = 1'b0;
    tick(4);
    d0 = done_seen;
    frame_start(8'h77);
    frame_bits(16, b);
    frame_end();
    checks++; if (b !== 16'h0000) begin errors++; $display("FAIL rst_next_bits: got %h expected 0000", b); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rst_next_overrun: got %b expected 1", overrun); end
    checks++; if (frame_ch !== 8'h77) begin errors++; $display("FAIL rst_next_ch: got %h expected 77", frame_ch); end
    checks++; if (done_seen - d0 !== 1 || abort_cnt !== 8'h00) begin errors++; $display("FAIL rst_next_done: got %0d/%h expected 1/00", done_seen - d0, abort_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_abort();
    test_load_collision();
    test_idle_sclk();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_sdo_responder.md
Name: adc_sdo_responder

Overview:
- Synthesizable responder for the 3-wire ADC serial read link (cs_n / sclk / SDO) that the sensor-scan controller masters while it steps the F1/F2 8:1 and F2 4:1 analog mux selects.
- Accepts parallel samples from an internal source (pattern generator or model), holds one, and shifts it out MSB-first on SDO.
- Each frame is tagged with the 8-bit mux channel latched at frame start.
- Used for on-board loopback and bench self-check of the scan controller without a real ADC.

Parameters:
- DATA_W, 16, sample bits per frame.
- CH_W, 8, channel tag width ({F2_4ADD[1:0], F2_8ADD[2:0], F1_8ADD[2:0]}).
- IDLE_LVL, 1, SDO level when cs_n high or after the last bit.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- cs_n  in  1  frame select from master, asynchronous to clk.
- sclk  in  1  serial clock from master, asynchronous, max clk/8.
- mux_sel  in  CH_W  live mux select lines.
- sample_data  in  DATA_W  next sample to transmit.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  holding register can accept a sample.
- sdo  out  1  serial data to master.
- frame_done  out  1  one-cycle pulse when a full frame completes.
- frame_ch  out  CH_W  channel latched at the start of the last frame.
- overrun  out  1  sticky flag: a frame started with no fresh sample.
- abort_cnt  out  8  saturating count of frames cut short by cs_n.

Behaviour:
- Reset (synchronous, active-high), all outputs:
  - sdo=IDLE_LVL, sample_ready=1, frame_done=0, frame_ch=0, overrun=0, abort_cnt=0.
  - Holding register empty, state IDLE.
- Input sync:
  - cs_n and sclk each pass through 2-FF synchronizers plus one edge-detect stage.
  - Edge detection therefore lags pins by 3 clk.
- Holding register:
  - A sample is accepted when sample_valid && sample_ready; sample_ready is then 0 the next cycle.
  - The register is emptied when a frame loads it; sample_ready returns to 1 the cycle after the load.
  - If a load and an accept occur in the same cycle, the load takes the old value and the new sample is stored (register stays full).
- States:
  - IDLE -> LOAD on synchronized cs_n falling edge.
  - LOAD (1 cycle):
    - Shift register <= holding register, or the last-sent sample if the holding register is empty; in that case set overrun.
    - frame_ch <= mux_sel; bit_cnt <= DATA_W-1.
    - sdo <= MSB.
    - -> SHIFT.
  - SHIFT:
    - On each synchronized sclk falling edge: if bit_cnt==0 -> DONE; else shift left, sdo <= next bit, bit_cnt-1.
    - The master samples sdo on sclk rising edges.
  - DONE:
    - sdo=IDLE_LVL.
    - frame_done pulses on entry.
    - Stay in DONE until cs_n rises -> IDLE.
- Abort: cs_n rises while in LOAD or SHIFT -> IDLE next cycle, sdo=IDLE_LVL, abort_cnt+1 (saturates at 255), no frame_done pulse.
- Simultaneous synchronized edges: if a cs_n edge and an sclk edge occur in the same cycle, the cs_n edge wins; a cs_n fall in DONE or SHIFT is ignored.
- Extra sclk edges in IDLE or DONE are ignored.
- overrun clears only on reset.
- Reset asserted mid-frame returns the block to the reset state immediately; the holding register contents are discarded.

Decomposition:
- Shared package `adc_link_pkg`:
  - DATA_W and CH_W defaults.
  - State encoding: IDLE=0, LOAD=1, SHIFT=2, DONE=3.
  - IDLE_LVL.
  - Helper for the channel concatenation order.
- One sub-module, `sync_edge_det`: 2-FF synchronizer with rise/fall pulses, instantiated once for cs_n and once for sclk.

Test Plan:
- Load 16'hA5C3, then run a 16-sclk frame at clk/10 with mux_sel=8'h2D -> SDO bits 1010_0101_1100_0011 sampled on sclk rises; frame_done pulses once; frame_ch=8'h2D; overrun=0.
- Run two back-to-back frames with only one sample loaded -> second frame repeats the previous sample and overrun=1; sample_ready is 1 between frames.
- Raise cs_n after 7 sclk edges -> sdo=1 within 4 clk, no frame_done, abort_cnt=1; the next full frame sends the newly loaded sample correctly.
- Assert sample_valid in the same cycle as LOAD (old=16'h1111, new=16'h2222) -> frame sends 1111; the next frame sends 2222; sample_ready=0 until that load.
- Assert reset mid-SHIFT -> next cycle sdo=1, sample_ready=1, abort_cnt=0, state IDLE; the following frame with overrun shows overrun=1 and data=0.
- Toggle sclk with cs_n high (20 edges) -> sdo stays 1, no state change, no counters change.
